sequence_checker: RTL and testbench

SEQUENCE_CHECKER -- requirements
Module: sequence_checker

---
 rtl/game_pkg.sv | 20 ++
 rtl/onehot_enc.sv | 21 ++
 rtl/sequence_checker.sv | 131 +++++++++++++
 tb/tb_sequence_checker.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and sizes for the memory-game sequence checker.
package game_pkg;

   localparam int unsigned MAX_SEQ_LEN = 16;
   localparam int unsigned SYM_W       = 2;
   localparam int unsigned BTN_W       = 4;
   localparam int unsigned IDX_W       = 4;
   localparam int unsigned LEN_W       = 5;

   typedef logic [SYM_W-1:0] sym_t;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WAIT_IN = 3'd1,
      S_CHECK   = 3'd2,
      S_PASS    = 3'd3,
      S_FAIL    = 3'd4
   } state_t;

endpackage

// File: rtl/onehot_enc.sv
// Converts a button press vector into a symbol and flags simultaneous presses.
module onehot_enc
   import game_pkg::*;
(
   input  logic [BTN_W-1:0] onehot,
   output sym_t             sym_c,
   output logic             any_c,
   output logic             multi_c
);

   always_comb begin
      sym_c   = '0;
      any_c   = |onehot;
      // Clearing the lowest set bit leaves something only if two or more were set.
      multi_c = |(onehot & (onehot - BTN_W'(1)));
      for (int k = BTN_W - 1; k >= 0; k--) begin
         if (onehot[k]) sym_c = SYM_W'(k);
      end
   end

endmodule

// File: rtl/sequence_checker.sv
// Checks a player's button presses against the stored sequence, one symbol at a time.
module sequence_checker
   import game_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 50_000_000,
   parameter int unsigned TW          = 26
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] seq_len,
   input  logic [BTN_W-1:0] btn_pulse,
   input  logic [SYM_W-1:0] exp_sym,
   output logic [IDX_W-1:0] rd_addr,
   output logic             busy,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic [IDX_W-1:0] idx
);

   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [TW-1:0]    timer_q, timer_d;
   sym_t             sym_q, sym_d;
   logic             pass_q, pass_d;
   logic             fail_q, fail_d;
   logic             timeout_q, timeout_d;
   logic             busy_q, busy_d;

   sym_t             enc_sym;
   logic             enc_any;
   logic             enc_multi;

   onehot_enc u_enc (
      .onehot  (btn_pulse),
      .sym_c   (enc_sym),
      .any_c   (enc_any),
      .multi_c (enc_multi)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         len_q     <= '0;
         timer_q   <= '0;
         sym_q     <= '0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         timer_q   <= timer_d;
         sym_q     <= sym_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         timeout_q <= timeout_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      len_d     = len_q;
      timer_d   = timer_q;
      sym_d     = sym_q;
      timeout_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (seq_len >= LEN_W'(1) && seq_len <= LEN_W'(MAX_SEQ_LEN)) begin
                  state_d = S_WAIT_IN;
                  idx_d   = '0;
                  timer_d = '0;
                  len_d   = seq_len;
               end else begin
                  state_d = S_FAIL;
               end
            end
         end
         S_WAIT_IN: begin
            // A press on the last allowed cycle still wins over the timeout.
            if (enc_multi) begin
               state_d = S_FAIL;
            end else if (enc_any) begin
               sym_d   = enc_sym;
               timer_d = '0;
               state_d = S_CHECK;
            end else if (timer_q == TMO_LAST) begin
               state_d   = S_FAIL;
               timeout_d = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_CHECK: begin
            if (sym_q != exp_sym) begin
               state_d = S_FAIL;
            end else begin
               idx_d = idx_q + IDX_W'(1);
               if ((LEN_W'(idx_q) + LEN_W'(1)) == len_q) state_d = S_PASS;
               else                                      state_d = S_WAIT_IN;
            end
         end
         S_PASS:  state_d = S_IDLE;
         S_FAIL:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      pass_d = (state_d == S_PASS);
      fail_d = (state_d == S_FAIL);
      busy_d = (state_d == S_WAIT_IN) || (state_d == S_CHECK);
   end

   assign rd_addr = idx_q;
   assign idx     = idx_q;
   assign busy    = busy_q;
   assign pass    = pass_q;
   assign fail    = fail_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker with a small registered sequence memory model.
module tb_sequence_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [4:0] seq_len = '0;
   logic [3:0] btn_pulse = '0;
   logic [1:0] exp_sym = '0;
   logic [3:0] rd_addr;
   logic       busy, pass, fail, timeout;
   logic [3:0] idx;

   logic [1:0] mem [16];
   int errors = 0;
   int checks = 0;
   int fail_seen = 0;

   sequence_checker #(.TIMEOUT_CYC(20), .TW(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .seq_len   (seq_len),
      .btn_pulse (btn_pulse),
      .exp_sym   (exp_sym),
      .rd_addr   (rd_addr),
      .busy      (busy),
      .pass      (pass),
      .fail      (fail),
      .timeout   (timeout),
      .idx       (idx)
   );

   always #5 clk = ~clk;

   // Sequence memory: one-cycle read latency.
   always @(posedge clk) exp_sym <= mem[rd_addr];

   // Verdict pulses must never overlap except fail with timeout.
   always @(negedge clk) begin
      if (fail) fail_seen++;
      if (rst && (pass || fail || timeout)) begin
         checks++;
         if ((pass && fail) || (timeout && !fail)) begin
            errors++;
            $display("FAIL verdict_overlap: pass=%b fail=%b timeout=%b required exclusive", pass, fail, timeout);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [4:0] len);
      start   = 1'b1;
      seq_len = len;
      tick();
      start   = 1'b0;
   endtask

   task automatic press(input logic [3:0] b);
      btn_pulse = b;
      tick();
      btn_pulse = '0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      checks += 6;
      if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      if (pass !== 1'b0)    begin errors++; $display("FAIL reset_pass: got %b want 0", pass); end
      if (fail !== 1'b0)    begin errors++; $display("FAIL reset_fail: got %b want 0", fail); end
      if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
      if (idx !== 4'd0)     begin errors++; $display("FAIL reset_idx: got %0d want 0", idx); end
      if (rd_addr !== 4'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_pass_round();
      int f0;
      mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
      f0 = fail_seen;
      do_start(5'd3);
      checks += 2;
      if (busy !== 1'b1) begin errors++; $display("FAIL pass_busy_after_start: got %b want 1", busy); end
      if (idx !== 4'd0)  begin errors++; $display("FAIL pass_idx_start: got %0d want 0", idx); end
      press(4'b0100);
      tick();
      checks++;
      if (idx !== 4'd1) begin errors++; $display("FAIL pass_idx_after_first: got %0d want 1", idx); end
      press(4'b0001);
      tick();
      checks++;
      if (rd_addr !== 4'd2) begin errors++; $display("FAIL pass_rd_addr: got %0d want 2", rd_addr); end
      press(4'b1000);
      checks++;
      if (pass !== 1'b0) begin errors++; $display("FAIL pass_early: got %b want 0 in check cycle", pass); end
      tick();
      checks += 3;
      if (pass !== 1'b1) begin errors++; $display("FAIL pass_pulse: got %b want 1", pass); end
      if (idx !== 4'd3)  begin errors++; $display("FAIL pass_idx_final: got %0d want 3", idx); end
      if (busy !== 1'b0) begin errors++; $display("FAIL pass_busy: got %b want 0", busy); end
      tick();
      checks += 3;
      if (pass !== 1'b0) begin errors++; $display("FAIL pass_width: got %b want 0", pass); end
      if (idx !== 4'd3)  begin errors++; $display("FAIL pass_idx_hold: got %0d want 3", idx); end
      if (fail_seen != f0) begin errors++; $display("FAIL pass_no_fail: got %0d fail pulses want 0", fail_seen - f0); end
   endtask

   task automatic test_wrong_symbol();
      do_start(5'd3);
      press(4'b0100);
      tick();
      press(4'b0010);
      checks++;
      if (fail !== 1'b0) begin errors++; $display("FAIL wrong_early: got %b want 0 in check cycle", fail); end
      tick();
      checks += 4;
      if (fail !== 1'b1)    begin errors++; $display("FAIL wrong_fail: got %b want 1", fail); end
      if (timeout !== 1'b0) begin errors++; $display("FAIL wrong_timeout: got %b want 0", timeout); end
      if (idx !== 4'd1)     begin errors++; $display("FAIL wrong_idx: got %0d want 1", idx); end
      if (pass !== 1'b0)    begin errors++; $display("FAIL wrong_pass: got %b want 0", pass); end
      tick();
      checks += 2;
      if (fail !== 1'b0) begin errors++; $display("FAIL wrong_width: got %b want 0", fail); end
      if (idx !== 4'd1)  begin errors++; $display("FAIL wrong_idx_hold: got %0d want 1", idx); end
   endtask

   task automatic test_timeout();
      int n;
      n = 0;
      do_start(5'd2);
      while (fail !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checks += 4;
      if (n != 20)          begin errors++; $display("FAIL timeout_cycles: got %0d want 20", n); end
      if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", timeout); end
      if (busy !== 1'b0)    begin errors++; $display("FAIL timeout_busy: got %b want 0", busy); end
      if (fail !== 1'b1)    begin errors++; $display("FAIL timeout_fail: got %b want 1", fail); end
      tick();
      checks += 2;
      if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", timeout); end
      if (busy !== 1'b0)    begin errors++; $display("FAIL timeout_busy_after: got %b want 0", busy); end
   endtask

   task automatic test_timeout_edge();
      mem[0] = 2'd2; mem[1] = 2'd1;
      do_start(5'd3);
      for (int i = 0; i < 19; i++) tick();
      checks++;
      if (fail !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL edge_before: fail=%b busy=%b want fail=0 busy=1", fail, busy);
      end
      press(4'b0100);
      checks++;
      if (fail !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL edge_last_press: fail=%b busy=%b want fail=0 busy=1", fail, busy);
      end
      tick();
      checks++;
      if (idx !== 4'd1) begin errors++; $display("FAIL edge_idx: got %0d want 1", idx); end
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_multi_and_bad_len();
      do_start(5'd3);
      press(4'b0011);
      checks += 2;
      if (fail !== 1'b1)    begin errors++; $display("FAIL multi_fail: got %b want 1", fail); end
      if (timeout !== 1'b0) begin errors++; $display("FAIL multi_timeout: got %b want 0", timeout); end
      tick();
      do_start(5'd0);
      checks += 2;
      if (fail !== 1'b1) begin errors++; $display("FAIL len0_fail: got %b want 1", fail); end
      if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy: got %b want 0", busy); end
      tick();
      do_start(5'd17);
      checks++;
      if (fail !== 1'b1) begin errors++; $display("FAIL len17_fail: got %b want 1", fail); end
      tick();
      press(4'b0001);
      checks++;
      if (busy !== 1'b0 || fail !== 1'b0) begin
         errors++; $display("FAIL idle_press: busy=%b fail=%b want 0 0", busy, fail);
      end
   endtask

   task automatic test_reset_mid();
      mem[0] = 2'd1; mem[1] = 2'd2; mem[2] = 2'd3;
      do_start(5'd3);
      press(4'b0010);
      tick();
      do_start(5'd5);
      checks += 2;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_start_busy: got %b want 1", busy); end
      if (idx !== 4'd1)  begin errors++; $display("FAIL busy_start_idx: got %0d want 1", idx); end
      press(4'b0100);
      tick();
      checks++;
      if (idx !== 4'd2) begin errors++; $display("FAIL mid_idx: got %0d want 2", idx); end
      rst = 1'b0;
      tick();
      checks += 4;
      if (busy !== 1'b0)    begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
      if (idx !== 4'd0)     begin errors++; $display("FAIL mid_rst_idx: got %0d want 0", idx); end
      if (rd_addr !== 4'd0) begin errors++; $display("FAIL mid_rst_rd_addr: got %0d want 0", rd_addr); end
      if (pass !== 1'b0 || fail !== 1'b0 || timeout !== 1'b0) begin
         errors++; $display("FAIL mid_rst_pulses: pass=%b fail=%b timeout=%b want 000", pass, fail, timeout);
      end
      rst = 1'b1;
      do_start(5'd1);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL first_start: got busy=%b want 1", busy); end
      press(4'b0010);
      tick();
      checks++;
      if (pass !== 1'b1) begin errors++; $display("FAIL len1_pass: got %b want 1", pass); end
      tick();
   endtask

   task automatic test_len16();
      logic [3:0] iv;
      logic [3:0] b;
      for (int i = 0; i < 16; i++) begin
         iv = 4'(i);
         mem[i] = iv[1:0] ^ iv[3:2];
      end
      do_start(5'd16);
      for (int i = 0; i < 16; i++) begin
         iv = 4'(i);
         checks++;
         if (rd_addr !== iv) begin errors++; $display("FAIL len16_rd_addr: got %0d want %0d", rd_addr, iv); end
         b = 4'b0001 << (iv[1:0] ^ iv[3:2]);
         press(b);
         tick();
      end
      checks += 3;
      if (pass !== 1'b1) begin errors++; $display("FAIL len16_pass: got %b want 1", pass); end
      if (idx !== 4'd0)  begin errors++; $display("FAIL len16_idx_wrap: got %0d want 0", idx); end
      if (fail !== 1'b0) begin errors++; $display("FAIL len16_fail: got %b want 0", fail); end
      tick();
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      test_reset();
      test_pass_round();
      test_wrong_symbol();
      test_timeout();
      test_timeout_edge();
      test_multi_and_bad_len();
      test_reset_mid();
      test_len16();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
